// File: rtl/reset_sequencer_if.sv
// Reset sequencer control/status bundle: lock and software request in,
// per-channel resets, completion flag and last reset cause out.
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              lock_i;
    logic              sw_rst_req_i;
    logic [NUM_CH-1:0] rst_o;
    logic              done_o;
    logic [1:0]        cause_o;

    modport master (
        output lock_i,
        output sw_rst_req_i,
        input  rst_o,
        input  done_o,
        input  cause_o
    );

    modport slave (
        input  lock_i,
        input  sw_rst_req_i,
        output rst_o,
        output done_o,
        output cause_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds all channels, waits for clock lock,
// then releases channels in index order, GAP_CYCLES apart.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reset_sequencer_if.slave  bus
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $fatal(1, "reset_sequencer: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $fatal(1, "reset_sequencer: GAP_CYCLES must be >= 1");
    end

    localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_RST  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        DONE
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [NUM_CH-1:0] rst_q;
    logic              done_q;
    logic [1:0]        cause_q;

    logic lock_lost;
    logic reenter;

    // Lock loss only matters once a channel may already be running.
    assign lock_lost = !bus.lock_i && (state_q != HOLD);
    assign reenter   = bus.sw_rst_req_i || lock_lost;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= CAUSE_RST;
        end else if (reenter) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= bus.sw_rst_req_i ? CAUSE_SW : CAUSE_LOCK;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST && bus.lock_i) begin
                        rst_q[0] <= 1'b0;
                        cnt_q    <= '0;
                        if (NUM_CH == 1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            state_q <= RELEASE;
                            idx_q   <= IW'(1);
                        end
                    end else if (cnt_q != HOLD_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_q[idx_q] <= 1'b0;
                        cnt_q        <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    rst_q  <= '0;
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_o   = rst_q;
    assign bus.done_o  = done_q;
    assign bus.cause_o = cause_q;

endmodule
